regfile4_onehot: RTL and testbench

//   4-entry x WIDTH register bank. Downstream consumer of the 2-to-4 write-address

---
 rtl/regfile4_onehot_if.sv | 37 +++
 rtl/regfile4_onehot.sv | 94 +++++++++
 tb/tb_regfile4_onehot.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/regfile4_onehot_if.sv
// Purpose : bundles the write port, both read ports and error status of the 4-entry bank.
// Latency : n/a (wiring only).
// Backpressure: none; the bank accepts a write or read every cycle.
//
// Signals (all owned by the master except where noted):
//   wr_en[3:0]     one-hot write select (bit i = decoder out_i)
//   wr_data        write data
//   rd_addr0/1     read port addresses
//   rd_data0/1     registered read data             (driven by slave)
//   rd_valid0/1    registered "entry written" flags (driven by slave)
//   wr_err         pulse after a multi-hot wr_en    (driven by slave)
//   err_count      saturating multi-hot count       (driven by slave)
interface regfile4_onehot_if #(
  parameter int WIDTH     = 32,
  parameter int ERR_CNT_W = 8
);
  logic [3:0]           wr_en;
  logic [WIDTH-1:0]     wr_data;
  logic [1:0]           rd_addr0;
  logic [1:0]           rd_addr1;
  logic [WIDTH-1:0]     rd_data0;
  logic [WIDTH-1:0]     rd_data1;
  logic                 rd_valid0;
  logic                 rd_valid1;
  logic                 wr_err;
  logic [ERR_CNT_W-1:0] err_count;

  modport master (
    output wr_en, wr_data, rd_addr0, rd_addr1,
    input  rd_data0, rd_data1, rd_valid0, rd_valid1, wr_err, err_count
  );

  modport slave (
    input  wr_en, wr_data, rd_addr0, rd_addr1,
    output rd_data0, rd_data1, rd_valid0, rd_valid1, wr_err, err_count
  );
endinterface

// File: rtl/regfile4_onehot.sv
// Purpose : 4 x WIDTH register bank, one-hot write port, two registered write-first read ports,
//           multi-hot write-enable detection with a saturating error counter.
// Latency : reads 1 cycle; a write is visible on a read port at the same edge (bypass).
// Backpressure: none; every cycle is accepted. Multi-hot writes are dropped and flagged.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; clears storage, valid bits and all outputs
//   bus    regfile4_onehot_if.slave (write port, read ports, wr_err, err_count)
module regfile4_onehot #(
  parameter int WIDTH     = 32,
  parameter int ERR_CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  regfile4_onehot_if.slave    bus
);

  logic [WIDTH-1:0]     mem [4];
  logic [3:0]           valid;

  logic [WIDTH-1:0]     rd_data0_q;
  logic [WIDTH-1:0]     rd_data1_q;
  logic                 rd_valid0_q;
  logic                 rd_valid1_q;
  logic                 wr_err_q;
  logic [ERR_CNT_W-1:0] err_count_q;

  logic                 wr_multi;
  logic                 wr_one;
  logic                 hit0;
  logic                 hit1;

  // Clearing the lowest set bit leaves something only if two or more bits were set.
  assign wr_multi = |(bus.wr_en & (bus.wr_en - 4'd1));
  assign wr_one   = (bus.wr_en != 4'd0) && !wr_multi;

  // Write-first bypass only for a legal write to the addressed entry.
  assign hit0 = wr_one && bus.wr_en[bus.rd_addr0];
  assign hit1 = wr_one && bus.wr_en[bus.rd_addr1];

  // Storage and valid bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        mem[i] <= '0;
      end
      valid <= '0;
    end else if (wr_one) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.wr_en[i]) begin
          mem[i]   <= bus.wr_data;
          valid[i] <= 1'b1;
        end
      end
    end
  end

  // Registered read ports
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data0_q  <= '0;
      rd_data1_q  <= '0;
      rd_valid0_q <= 1'b0;
      rd_valid1_q <= 1'b0;
    end else begin
      rd_data0_q  <= hit0 ? bus.wr_data : mem[bus.rd_addr0];
      rd_data1_q  <= hit1 ? bus.wr_data : mem[bus.rd_addr1];
      rd_valid0_q <= hit0 | valid[bus.rd_addr0];
      rd_valid1_q <= hit1 | valid[bus.rd_addr1];
    end
  end

  // Error pulse and saturating counter (holds at all-ones until reset)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_err_q    <= 1'b0;
      err_count_q <= '0;
    end else begin
      wr_err_q <= wr_multi;
      if (wr_multi && (err_count_q != '1)) begin
        err_count_q <= err_count_q + ERR_CNT_W'(1);
      end
    end
  end

  assign bus.rd_data0  = rd_data0_q;
  assign bus.rd_data1  = rd_data1_q;
  assign bus.rd_valid0 = rd_valid0_q;
  assign bus.rd_valid1 = rd_valid1_q;
  assign bus.wr_err    = wr_err_q;
  assign bus.err_count = err_count_q;

endmodule

// File: tb/tb_regfile4_onehot.sv
// Purpose : randomized and directed checking of regfile4_onehot against an array-based model.
// Latency : expects read data one edge after address; wr_err one edge after a multi-hot sample.
// Backpressure: none.
module tb_regfile4_onehot;

  localparam int WIDTH     = 32;
  localparam int ERR_CNT_W = 8;
  localparam int CNT_MAX   = (1 << ERR_CNT_W) - 1;

  logic clk;
  logic rst_n;

  regfile4_onehot_if #(.WIDTH(WIDTH), .ERR_CNT_W(ERR_CNT_W)) bus ();

  regfile4_onehot #(.WIDTH(WIDTH), .ERR_CNT_W(ERR_CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #200 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model: plain arrays updated from the behavioural rules
  logic [WIDTH-1:0] m_mem [4];
  bit               m_val [4];
  int               m_cnt;
  logic [WIDTH-1:0] e_rd0, e_rd1;
  bit               e_v0, e_v1, e_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_mem[i] = '0;
      m_val[i] = 0;
    end
    m_cnt = 0;
    e_rd0 = '0; e_rd1 = '0; e_v0 = 0; e_v1 = 0; e_err = 0;
  endtask

  task automatic check_outputs(input string ctx);
    chk({ctx, ".rd_data0"},  bus.rd_data0,  e_rd0);
    chk({ctx, ".rd_data1"},  bus.rd_data1,  e_rd1);
    chk({ctx, ".rd_valid0"}, 32'(bus.rd_valid0), 32'(e_v0));
    chk({ctx, ".rd_valid1"}, 32'(bus.rd_valid1), 32'(e_v1));
    chk({ctx, ".wr_err"},    32'(bus.wr_err),    32'(e_err));
    chk({ctx, ".err_count"}, 32'(bus.err_count), 32'(m_cnt));
  endtask

  // Called while clk is low: apply inputs, let one rising edge happen, update
  // the model from its pre-edge state, then compare on the following falling edge.
  task automatic do_cycle(input string ctx, input logic [3:0] we, input logic [WIDTH-1:0] wd,
                          input logic [1:0] a0, input logic [1:0] a1);
    int n;
    int idx;
    bus.wr_en    = we;
    bus.wr_data  = wd;
    bus.rd_addr0 = a0;
    bus.rd_addr1 = a1;
    @(posedge clk);
    n   = $countones(we);
    idx = -1;
    for (int i = 0; i < 4; i++) if (we[i]) idx = i;
    if (n == 1 && idx == int'(a0)) begin e_rd0 = wd; e_v0 = 1; end
    else begin e_rd0 = m_mem[a0]; e_v0 = m_val[a0]; end
    if (n == 1 && idx == int'(a1)) begin e_rd1 = wd; e_v1 = 1; end
    else begin e_rd1 = m_mem[a1]; e_v1 = m_val[a1]; end
    e_err = (n >= 2);
    if (n >= 2 && m_cnt < CNT_MAX) m_cnt++;
    if (n == 1) begin
      m_mem[idx] = wd;
      m_val[idx] = 1;
    end
    @(negedge clk);
    check_outputs(ctx);
  endtask

  // Gate-style 2-to-4 decoder feeding wr_en
  function automatic logic [3:0] decode(input logic en, input logic [1:0] a);
    logic [3:0] o;
    o[0] = en & ~a[1] & ~a[0];
    o[1] = en & ~a[1] &  a[0];
    o[2] = en &  a[1] & ~a[0];
    o[3] = en &  a[1] &  a[0];
    return o;
  endfunction

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not complete, time %0t expected below 10000000", $time);
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0]       we;
    logic [WIDTH-1:0] wd;
    logic [1:0]       a;

    rst_n        = 1'b0;
    bus.wr_en    = 4'd0;
    bus.wr_data  = '0;
    bus.rd_addr0 = 2'd0;
    bus.rd_addr1 = 2'd0;
    model_reset();

    // Reset state, then read every address
    #10;
    check_outputs("reset");
    #90;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) do_cycle("rd_empty", 4'd0, '0, 2'(i), 2'(i));

    // Fill each entry through a distinct one-hot enable, then read back
    for (int i = 0; i < 4; i++) do_cycle("fill", 4'(1 << i), 32'hA5A5_0001 + 32'(i), 2'd0, 2'd3);
    for (int i = 0; i < 4; i++) do_cycle("readback", 4'd0, '0, 2'(i), 2'(3 - i));

    // Same-edge bypass on port 0, port 1 untouched
    do_cycle("bypass", 4'b0100, 32'hDEAD_BEEF, 2'd2, 2'd1);

    // Single multi-hot attempt: no write, one-cycle pulse
    do_cycle("multi", 4'b0011, 32'hFFFF_FFFF, 2'd0, 2'd1);
    do_cycle("after_multi", 4'd0, '0, 2'd0, 2'd1);

    // Saturation of the error counter
    for (int i = 0; i < 300; i++)
      do_cycle("sat", 4'b1111, $urandom, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    for (int i = 0; i < 4; i++) do_cycle("post_sat", 4'd0, '0, 2'(i), 2'(3 - i));

    // Randomized traffic, biased towards legal one-hot writes
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 3))
        0:       we = 4'd0;
        1, 2:    we = 4'(1 << $urandom_range(0, 3));
        default: we = 4'($urandom_range(0, 15));
      endcase
      wd = $urandom;
      do_cycle("rand", we, wd, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    end

    // Asynchronous reset asserted mid-cycle during a write to entry 0
    bus.wr_en    = 4'b0001;
    bus.wr_data  = 32'h1234_5678;
    bus.rd_addr0 = 2'd0;
    bus.rd_addr1 = 2'd0;
    @(posedge clk);
    #50;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    do_cycle("post_rst", 4'd0, '0, 2'd0, 2'd0);

    // Decoder-driven write: enable = 1, address = 3
    do_cycle("dec_wr", decode(1'b1, 2'd3), 32'hC0DE_0003, 2'd0, 2'd1);
    for (int i = 0; i < 4; i++) begin
      a = 2'(i);
      do_cycle("dec_rd", decode(1'b0, a), '0, a, 2'(3 - i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
